// File: rtl/fifo_frame_writer.sv
// fifo_frame_writer: write-side frame producer for the asynchronous FIFO.
// Payload words pass straight through to the FIFO write port. After the last
// word of each frame, a length word and then a checksum word are written.
// The read side can therefore delimit and verify frames without a sideband.
module fifo_frame_writer #(
    parameter int SIZE_DATA = 8,
    parameter int SIZE_FCNT = 16
) (
    input  logic                 i_clk_wr,
    input  logic                 i_rst_n,
    input  logic                 i_s_valid,
    input  logic [SIZE_DATA-1:0] i_s_data,
    input  logic                 i_s_last,
    output logic                 o_s_ready,
    input  logic                 i_full,
    output logic                 o_wr_en,
    output logic [SIZE_DATA-1:0] o_data_wr,
    output logic                 o_busy,
    output logic [SIZE_FCNT-1:0] o_frame_cnt,
    output logic                 o_len_sat
);

    typedef enum logic [1:0] {
        ST_DATA = 2'd0,
        ST_LEN  = 2'd1,
        ST_CHK  = 2'd2
    } state_t;

    localparam logic [SIZE_DATA-1:0] LEN_MAX  = {SIZE_DATA{1'b1}};
    localparam logic [SIZE_DATA-1:0] LEN_ZERO = {SIZE_DATA{1'b0}};
    localparam logic [SIZE_DATA-1:0] LEN_ONE  = {{(SIZE_DATA-1){1'b0}}, 1'b1};
    localparam logic [SIZE_FCNT-1:0] FCNT_ONE = {{(SIZE_FCNT-1){1'b0}}, 1'b1};

    // Length counter increment that sticks at the largest representable value
    function automatic logic [SIZE_DATA-1:0] sat_inc(input logic [SIZE_DATA-1:0] v);
        if (v == LEN_MAX) begin
            return v;
        end else begin
            return v + LEN_ONE;
        end
    endfunction

    state_t                 state_q,     state_d;
    logic [SIZE_DATA-1:0]   len_cnt_q,   len_cnt_d;
    logic [SIZE_DATA-1:0]   chk_acc_q,   chk_acc_d;
    logic [SIZE_DATA-1:0]   len_q,       len_d;
    logic [SIZE_DATA-1:0]   chk_q,       chk_d;
    logic [SIZE_FCNT-1:0]   frame_cnt_q, frame_cnt_d;
    logic                   len_sat_q,   len_sat_d;
    logic                   xfer_s;

    // State and trailer registers; everything clears on the shared FIFO reset
    always_ff @(posedge i_clk_wr or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_DATA;
            len_cnt_q   <= LEN_ZERO;
            chk_acc_q   <= LEN_ZERO;
            len_q       <= LEN_ZERO;
            chk_q       <= LEN_ZERO;
            frame_cnt_q <= {SIZE_FCNT{1'b0}};
            len_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_cnt_q   <= len_cnt_d;
            chk_acc_q   <= chk_acc_d;
            len_q       <= len_d;
            chk_q       <= chk_d;
            frame_cnt_q <= frame_cnt_d;
            len_sat_q   <= len_sat_d;
        end
    end

    // Next-state and FIFO-port decode; a write is only ever strobed while not full
    always_comb begin
        state_d     = state_q;
        len_cnt_d   = len_cnt_q;
        chk_acc_d   = chk_acc_q;
        len_d       = len_q;
        chk_d       = chk_q;
        frame_cnt_d = frame_cnt_q;
        len_sat_d   = len_sat_q;
        o_s_ready   = 1'b0;
        o_wr_en     = 1'b0;
        o_data_wr   = i_s_data;
        xfer_s      = 1'b0;
        case (state_q)
            ST_DATA: begin
                o_s_ready = ~i_full;
                xfer_s    = i_s_valid & ~i_full;
                o_wr_en   = xfer_s;
                o_data_wr = i_s_data;
                if (xfer_s) begin
                    len_cnt_d = sat_inc(len_cnt_q);
                    chk_acc_d = chk_acc_q + i_s_data;
                    if (i_s_last) begin
                        len_d   = sat_inc(len_cnt_q);
                        chk_d   = chk_acc_q + i_s_data;
                        state_d = ST_LEN;
                        if (len_cnt_q == LEN_MAX) begin
                            len_sat_d = 1'b1;
                        end else begin
                            len_sat_d = len_sat_q;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_LEN: begin
                o_data_wr = len_q;
                o_wr_en   = ~i_full;
                if (!i_full) begin
                    state_d = ST_CHK;
                end else begin
                    state_d = ST_LEN;
                end
            end
            ST_CHK: begin
                o_data_wr = chk_q;
                o_wr_en   = ~i_full;
                if (!i_full) begin
                    state_d     = ST_DATA;
                    len_cnt_d   = LEN_ZERO;
                    chk_acc_d   = LEN_ZERO;
                    frame_cnt_d = frame_cnt_q + FCNT_ONE;
                end else begin
                    state_d = ST_CHK;
                end
            end
            default: begin
                state_d   = ST_DATA;
                len_cnt_d = LEN_ZERO;
                chk_acc_d = LEN_ZERO;
            end
        endcase
    end

    assign o_busy      = (state_q != ST_DATA) | (len_cnt_q != LEN_ZERO);
    assign o_frame_cnt = frame_cnt_q;
    assign o_len_sat   = len_sat_q;

endmodule
